// File: rtl/mem_access_ctrl.sv
// Load/store front end for a byte-addressed 1 KiB memory: checks alignment,
// drives one memory access per request and returns sign/zero-extended load data.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_type,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where resp_valid && resp_ready. Payloads
  // are held stable by their producer until the transfer edge.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  state_t state;
  logic   lat_we;
  logic   lat_unsigned;
  logic   req_bad;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign dbg_state  = state;

  always_comb begin
    req_bad = 1'b0;
    if (req_size == SIZE_RSVD)
      req_bad = 1'b1;
    else if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
      req_bad = 1'b1;
    else if (req_size == SIZE_HALF && req_addr[0] != 1'b0)
      req_bad = 1'b1;
  end

  // Memory returns bytes addr..addr+3 little-endian, so the addressed
  // item is always right-justified in the returned word.
  function automatic logic [31:0] extract(input logic [31:0] d,
                                          input logic [1:0]  size,
                                          input logic        uns);
    logic [31:0] r;
    r = 32'd0;
    case (size)
      SIZE_WORD: r = d;
      SIZE_HALF: r = {{16{~uns & d[15]}}, d[15:0]};
      SIZE_BYTE: r = {{24{~uns & d[7]}}, d[7:0]};
      default:   r = 32'd0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      mem_addr     <= 10'd0;
      mem_wdata    <= 32'd0;
      mem_type     <= 2'd0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      resp_rdata   <= 32'd0;
      resp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              resp_rdata <= 32'd0;
              resp_err   <= 1'b1;
              state      <= RESP;
            end else begin
              lat_we       <= req_we;
              lat_unsigned <= req_unsigned;
              mem_addr     <= req_addr;
              mem_wdata    <= req_wdata;
              mem_type     <= req_size;
              mem_read     <= ~req_we;
              mem_write    <= req_we;
              state        <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // Store commits in memory on this same edge; load data was
          // presented on the preceding falling edge.
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= lat_we ? 32'd0 : extract(mem_rdata, mem_type, lat_unsigned);
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            state      <= IDLE;
          end
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural byte memory that
// answers reads on the falling edge and commits writes on the rising edge.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [9:0]  req_addr = 10'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_type;
  logic [31:0] mem_rdata = 32'd0;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;

  logic [7:0] mem [0:1023];

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_type(mem_type), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model
  always @(negedge clk) begin
    logic [9:0] a;
    a = mem_addr;
    if (mem_read)
      mem_rdata <= {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (mem_read && mem_write) both_cnt++;
  end

  always @(posedge clk) begin
    logic [9:0] a;
    a = mem_addr;
    if (mem_write) begin
      mem[a] <= mem_wdata[7:0];
      if (mem_type != 2'd2) mem[a + 10'd1] <= mem_wdata[15:8];
      if (mem_type == 2'd0) begin
        mem[a + 10'd2] <= mem_wdata[23:16];
        mem[a + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  // driver: issue one request from IDLE, wait for the response, consume it.
  // lat counts cycles after the accept edge until resp_valid is seen.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [9:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
    n_checks++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err got=%0b exp=0", resp_err); end
    n_checks++; if (resp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
    n_checks++; if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("FAIL reset_mem_rw got=%b exp=00", {mem_read, mem_write}); end
    n_checks++; if (mem_addr !== 10'd0 || mem_wdata !== 32'd0 || mem_type !== 2'd0) begin
      n_bad++; $display("FAIL reset_mem_bus got addr=%0d wdata=%h type=%0d exp all 0", mem_addr, mem_wdata, mem_type); end
    n_checks++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_word();
    logic [31:0] d; logic e; int lat;
    rd_cnt = 0; wr_cnt = 0;
    issue(1'b0, 2'd0, 1'b0, 10'd1020, 32'd0, d, e, lat);
    n_checks++; if (d !== 32'h0A48656C) begin n_bad++; $display("FAIL lw1020_data got=%h exp=0a48656c", d); end
    n_checks++; if (e !== 1'b0) begin n_bad++; $display("FAIL lw1020_err got=%0b exp=0", e); end
    n_checks++; if (lat !== 2) begin n_bad++; $display("FAIL lw1020_latency got=%0d exp=2", lat); end
    n_checks++; if (rd_cnt !== 1 || wr_cnt !== 0) begin n_bad++; $display("FAIL lw1020_pulses got rd=%0d wr=%0d exp rd=1 wr=0", rd_cnt, wr_cnt); end
  endtask

  task automatic test_byte();
    logic [31:0] d; logic e; int lat;
    wr_cnt = 0;
    issue(1'b1, 2'd2, 1'b0, 10'd0, 32'h00000080, d, e, lat);
    n_checks++; if (d !== 32'd0 || e !== 1'b0) begin n_bad++; $display("FAIL sb0_resp got data=%h err=%0b exp data=0 err=0", d, e); end
    n_checks++; if (wr_cnt !== 1) begin n_bad++; $display("FAIL sb0_pulses got wr=%0d exp=1", wr_cnt); end
    issue(1'b0, 2'd2, 1'b0, 10'd0, 32'd0, d, e, lat);
    n_checks++; if (d !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb0_signed got=%h exp=ffffff80", d); end
    issue(1'b0, 2'd2, 1'b1, 10'd0, 32'd0, d, e, lat);
    n_checks++; if (d !== 32'h00000080) begin n_bad++; $display("FAIL lb0_unsigned got=%h exp=00000080", d); end
  endtask

  task automatic test_half();
    logic [31:0] d; logic e; int lat;
    issue(1'b1, 2'd1, 1'b0, 10'd4, 32'h0000BEEF, d, e, lat);
    n_checks++; if (lat !== 2) begin n_bad++; $display("FAIL sh4_latency got=%0d exp=2", lat); end
    issue(1'b0, 2'd1, 1'b0, 10'd4, 32'd0, d, e, lat);
    n_checks++; if (d !== 32'hFFFFBEEF) begin n_bad++; $display("FAIL lh4_signed got=%h exp=ffffbeef", d); end
    issue(1'b0, 2'd1, 1'b1, 10'd4, 32'd0, d, e, lat);
    n_checks++; if (d !== 32'h0000BEEF) begin n_bad++; $display("FAIL lh4_unsigned got=%h exp=0000beef", d); end
    issue(1'b0, 2'd0, 1'b0, 10'd4, 32'd0, d, e, lat);
    n_checks++; if (d !== 32'h0000BEEF) begin n_bad++; $display("FAIL lw4 got=%h exp=0000beef", d); end
    issue(1'b0, 2'd2, 1'b0, 10'd5, 32'd0, d, e, lat);
    n_checks++; if (d !== 32'hFFFFFFBE) begin n_bad++; $display("FAIL lb5_signed got=%h exp=ffffffbe", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int lat;
    logic [1:0]  sz [4] = '{2'd0, 2'd1, 2'd3, 2'd0};
    logic [9:0]  ad [4] = '{10'd1022, 10'd1021, 10'd0, 10'd2};
    logic        wv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      rd_cnt = 0; wr_cnt = 0;
      issue(wv[i], sz[i], 1'b0, ad[i], 32'hDEADBEEF, d, e, lat);
      n_checks++; if (e !== 1'b1 || d !== 32'd0) begin n_bad++; $display("FAIL err%0d_resp got err=%0b data=%h exp err=1 data=0", i, e, d); end
      n_checks++; if (lat !== 1) begin n_bad++; $display("FAIL err%0d_latency got=%0d exp=1", i, lat); end
      n_checks++; if (rd_cnt !== 0 || wr_cnt !== 0) begin n_bad++; $display("FAIL err%0d_pulses got rd=%0d wr=%0d exp 0 0", i, rd_cnt, wr_cnt); end
    end
  endtask

  task automatic test_backpressure();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 10'd1020;
    @(posedge clk); #1;
    // next request is already waiting and must not be taken until release
    req_size = 2'd2; req_unsigned = 1'b1; req_addr = 10'd1021;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0A48656C || req_ready !== 1'b0) begin
        n_bad++; $display("FAIL hold%0d got valid=%0b data=%h ready=%0b exp 1 0a48656c 0", i, resp_valid, resp_rdata, req_ready); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL release got ready=%0b valid=%0b exp 1 0", req_ready, resp_valid); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL second_accept got ready=%0b exp=0", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h00000065) begin
      n_bad++; $display("FAIL second_resp got valid=%0b data=%h exp 1 00000065", resp_valid, resp_rdata); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int rdy = 0;
    int vld = 0;
    both_cnt = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 10'd1020;
    resp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (req_ready) rdy++;
      if (resp_valid) begin
        vld++;
        n_checks++; if (resp_rdata !== 32'h0A48656C) begin n_bad++; $display("FAIL b2b_data%0d got=%h exp=0a48656c", i, resp_rdata); end
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    n_checks++; if (rdy !== 3 || vld !== 3) begin n_bad++; $display("FAIL b2b_rate got accepts=%0d resps=%0d exp 3 3", rdy, vld); end
    n_checks++; if (both_cnt !== 0) begin n_bad++; $display("FAIL rw_exclusive got=%0d exp=0", both_cnt); end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] d; logic e; int lat;
    wr_cnt = 0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 10'd8; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL sw8_access got mem_write=%0b exp=1", mem_write); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (mem_write !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 10'd0) begin
      n_bad++; $display("FAIL async_rst got wr=%0b ready=%0b addr=%0d exp 0 1 0", mem_write, req_ready, mem_addr); end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_no_resp got=%0b exp=0", resp_valid); end
    end
    n_checks++; if (wr_cnt !== 0) begin n_bad++; $display("FAIL rst_no_commit got wr=%0d exp=0", wr_cnt); end
    issue(1'b0, 2'd0, 1'b0, 10'd8, 32'd0, d, e, lat);
    n_checks++; if (d !== 32'd0 || e !== 1'b0) begin n_bad++; $display("FAIL lw8 got data=%h err=%0b exp 0 0", d, e); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[1020] = 8'h6C; mem[1021] = 8'h65; mem[1022] = 8'h48; mem[1023] = 8'h0A;
    test_reset();
    test_load_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
